// File: rtl/divider_seq_8.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// results presented on the shared bus through active-low tristate enables.
module divider_seq_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             quo_en,
  input  logic             rem_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [2:0]       cnt_q;

  logic [WIDTH:0]   partialRem;
  logic [WIDTH:0]   diffRem;

  // The partial remainder stays below twice the divisor, so nine bits never
  // overflow and diffRem[WIDTH] is a clean borrow flag.
  assign partialRem = {rem_q, quo_q[WIDTH-1]};
  assign diffRem    = partialRem - {1'b0, div_q};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            div_q <= divisor;
            cnt_q <= '0;
            done  <= 1'b0;
            if (divisor != '0) begin
              state_q  <= CALC;
              quo_q    <= dividend;
              rem_q    <= '0;
              busy     <= 1'b1;
              div_zero <= 1'b0;
            end else begin
              state_q  <= DONE;
              quo_q    <= '1;
              rem_q    <= dividend;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!diffRem[WIDTH]) begin
            rem_q <= diffRem[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= partialRem[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Quotient wins when both enables are asserted.
  assign bus_out = !quo_en ? quo_q :
                   !rem_en ? rem_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_divider_seq_8.sv
// Directed and table-driven bench for divider_seq_8; a pull-up on the bus
// makes an undriven bus read as 8'hFF.
module tb_divider_seq_8;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       quo_en = 1'b1;
  logic       rem_en = 1'b1;
  wire  [7:0] busW;
  logic       busy;
  logic       done;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[12];

  divider_seq_8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quo_en   (quo_en),
    .rem_en   (rem_en),
    .bus_out  (busW),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  for (genvar i = 0; i < 8; i++) begin : gPull
    pullup pu (busW[i]);
  end

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launches one operation: operands and start are held across exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic readBus(output logic [7:0] q, output logic [7:0] r);
    quo_en = 1'b0;
    rem_en = 1'b1;
    #1 q = busW;
    quo_en = 1'b1;
    rem_en = 1'b0;
    #1 r = busW;
    rem_en = 1'b1;
  endtask

  task automatic runVector(input vec_t v);
    int         cyc;
    logic [7:0] q;
    logic [7:0] r;
    applyStimulus(v.a, v.b);
    if (v.b != 8'd0) begin
      checkOutput("busy_after_accept", {15'd0, busy}, 16'd1);
      checkOutput("done_after_accept", {15'd0, done}, 16'd0);
      waitDone(cyc);
      checkOutput("latency", cyc[15:0], 16'd8);
    end else begin
      checkOutput("dz_done_1clk", {15'd0, done}, 16'd1);
      checkOutput("dz_busy_never", {15'd0, busy}, 16'd0);
    end
    readBus(q, r);
    checkOutput("quotient", {8'd0, q}, {8'd0, v.q});
    checkOutput("remainder", {8'd0, r}, {8'd0, v.r});
    checkOutput("div_zero", {15'd0, div_zero}, {15'd0, v.dz});
  endtask

  initial begin
    int         cyc;
    int         total;
    logic [7:0] q;
    logic [7:0] r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;

    vecs[0]  = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
    vecs[3]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[4]  = '{a: 8'd77,  b: 8'd0,   q: 8'hFF,  r: 8'd77, dz: 1'b1};
    vecs[5]  = '{a: 8'd100, b: 8'd3,   q: 8'd33,  r: 8'd1,  dz: 1'b0};
    vecs[6]  = '{a: 8'd9,   b: 8'd2,   q: 8'd4,   r: 8'd1,  dz: 1'b0};
    vecs[7]  = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vecs[8]  = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0,  dz: 1'b0};
    vecs[9]  = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,  dz: 1'b0};
    vecs[10] = '{a: 8'd254, b: 8'd127, q: 8'd2,   r: 8'd0,  dz: 1'b0};
    vecs[11] = '{a: 8'd13,  b: 8'd4,   q: 8'd3,   r: 8'd1,  dz: 1'b0};

    #2;
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    checkOutput("rst_div_zero", {15'd0, div_zero}, 16'd0);
    #1 checkOutput("rst_bus_float", {8'd0, busW}, 16'h00FF);
    readBus(q, r);
    checkOutput("rst_quotient", {8'd0, q}, 16'd0);
    checkOutput("rst_remainder", {8'd0, r}, 16'd0);
    #6 clr = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      runVector(vecs[i]);
    end

    // Enable priority and float, using a known 200/7 result.
    runVector(vecs[0]);
    quo_en = 1'b1;
    rem_en = 1'b1;
    #1 checkOutput("bus_float_both_high", {8'd0, busW}, 16'h00FF);
    quo_en = 1'b0;
    rem_en = 1'b0;
    #1 checkOutput("bus_both_low_quotient", {8'd0, busW}, 16'h001C);
    quo_en = 1'b1;
    rem_en = 1'b1;

    // Back-to-back: start stays high through 5/9, then 255/255 is taken at the first DONE edge.
    dividend = 8'd5;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("b2b_busy_first", {15'd0, busy}, 16'd1);
    waitDone(cyc);
    checkOutput("b2b_latency_first", cyc[15:0], 16'd8);
    readBus(q, r);
    checkOutput("b2b_q_first", {8'd0, q}, 16'd0);
    checkOutput("b2b_r_first", {8'd0, r}, 16'd5);
    dividend = 8'd255;
    divisor  = 8'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_done_drops", {15'd0, done}, 16'd0);
    checkOutput("b2b_busy_second", {15'd0, busy}, 16'd1);
    waitDone(cyc);
    checkOutput("b2b_latency_second", cyc[15:0], 16'd8);
    readBus(q, r);
    checkOutput("b2b_q_second", {8'd0, q}, 16'd1);
    checkOutput("b2b_r_second", {8'd0, r}, 16'd0);

    // start with new operands in the middle of CALC must be ignored.
    applyStimulus(8'd100, 8'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc);
    total = cyc + 3;
    checkOutput("ignore_latency", total[15:0], 16'd8);
    readBus(q, r);
    checkOutput("ignore_q", {8'd0, q}, 16'd33);
    checkOutput("ignore_r", {8'd0, r}, 16'd1);

    // Asynchronous clear partway through CALC, then a fresh division.
    applyStimulus(8'd100, 8'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #1 clr = 1'b1;
    #1;
    checkOutput("clr_busy", {15'd0, busy}, 16'd0);
    checkOutput("clr_done", {15'd0, done}, 16'd0);
    readBus(q, r);
    checkOutput("clr_q", {8'd0, q}, 16'd0);
    checkOutput("clr_r", {8'd0, r}, 16'd0);
    clr = 1'b0;
    #1;
    applyStimulus(8'd9, 8'd2);
    waitDone(cyc);
    checkOutput("post_clr_latency", cyc[15:0], 16'd8);
    readBus(q, r);
    checkOutput("post_clr_q", {8'd0, q}, 16'd4);
    checkOutput("post_clr_r", {8'd0, r}, 16'd1);

    // Random operand pairs against the arithmetic reference.
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      applyStimulus(a, b);
      waitDone(cyc);
      readBus(q, r);
      checkOutput("sweep_qr", {q, r}, {eq, er});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
